unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency SRAM between the IF stage (instruction fetch)
//  and the MEM stage (data load/store) of the 5-stage MIPS pipeline.
//  Sequences each access as issue -> wait -> respond.
//  Returns per-requester ready/stall; the top level ORs those stalls into the pipeline freeze.
//  MEM has priority over IF; a starvation guard bounds the IF wait.
// PARAMETERS
//  WORD_LEN      32  data width
//  ADDR_LEN      32  address width
//  MEM_LATENCY   2   cycles from sram_en to valid sram_rdata (>=1)
//  STARVE_LIMIT  4   consecutive MEM grants with IF pending before IF is forced (>=1)
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous, active-high reset
//  if_req     in   1         fetch request; held with if_addr until if_ready or flush
//  if_addr    in   ADDR_LEN  fetch address (PC)
//  if_flush   in   1         branch taken: discard in-flight/unreturned fetch
//  if_rdata   out  WORD_LEN  fetched instruction, valid when if_ready
//  if_ready   out  1         one-cycle completion pulse for IF
//  if_stall   out  1         if_req & ~if_ready
//  mem_req    in   1         data request (MEM_R_EN | MEM_W_EN); held until mem_ready
//  mem_we     in   1         1 = store, 0 = load
//  mem_addr   in   ADDR_LEN  data address (ALU result)
//  mem_wdata  in   WORD_LEN  store value
//  mem_rdata  out  WORD_LEN  load value, valid when mem_ready
//  mem_ready  out  1         one-cycle completion pulse for MEM
//  mem_stall  out  1         mem_req & ~mem_ready
//  sram_en    out  1         SRAM access strobe, exactly one cycle per access
//  sram_we    out  1         SRAM write enable, qualified by sram_en
//  sram_addr  out  ADDR_LEN  SRAM address, registered
//  sram_wdata out  WORD_LEN  SRAM write data, registered
//  sram_rdata in   WORD_LEN  SRAM read data, valid MEM_LATENCY cycles after sram_en
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0; lat_cnt, starve_cnt, grant, drop_flag all 0.
//  FSM
//   IDLE:  if mem_req|if_req, pick the grantee and register sram_en/we/addr/wdata from it,
//          then go to ISSUE. Otherwise stay.
//   ISSUE: sram_en=1 for exactly this cycle; load lat_cnt=MEM_LATENCY; go to WAIT.
//   WAIT:  decrement lat_cnt each cycle. At lat_cnt==1, capture sram_rdata into the
//          grantee's rdata register; go to RESP. WAIT lasts MEM_LATENCY cycles.
//   RESP:  pulse the grantee's ready for one cycle; all requests are ignored; go to IDLE.
//  Timing: request seen in cycle 0 (IDLE) -> sram_en in cycle 1 -> ready in cycle
//   MEM_LATENCY+2. Stores use the same timing; their rdata register is unchanged.
//   Back-to-back throughput: one access per MEM_LATENCY+3 cycles.
//  Grant rule in IDLE
//   - mem_req wins, unless if_req is set and starve_cnt==STARVE_LIMIT; then IF wins.
//   - starve_cnt: +1 on each MEM grant while if_req=1 (saturates at STARVE_LIMIT).
//     Cleared on an IF grant or whenever if_req=0.
//  Flush
//   - drop_flag is set if if_flush=1 while grant=IF in ISSUE or WAIT.
//   - if_ready = (state==RESP) & grant==IF & ~drop_flag & ~if_flush (combinational).
//     A dropped fetch still runs to completion on the SRAM; only the response is discarded.
//   - drop_flag clears on the transition to IDLE.
//   - if_flush has no effect on MEM accesses or on IDLE.
//  Requests held stable by the requester are assumed unchanged. Inputs are sampled only in IDLE.
//  Reset mid-access: on the next edge go to IDLE, sram_en=0, no ready pulse for the aborted access.
//  rdata registers hold their value until the next capture for the same requester.
// TESTING
//  1 L=2, if_req addr 0x10 at cyc0 -> sram_en/addr 0x10/we=0 at cyc1; sram_rdata=0xDEADBEEF
//    at cyc3 -> if_ready=1, if_rdata=0xDEADBEEF at cyc4; if_stall=1 cyc0-3, 0 at cyc4.
//  2 if_req(0x20) and mem_req store (0x40, 0x55) together at cyc0 -> sram_we=1, addr 0x40,
//    wdata 0x55 at cyc1; mem_ready cyc4; fetch sram_en cyc6 with addr 0x20; if_ready cyc9.
//  3 STARVE_LIMIT=2, mem_req and if_req held continuously -> grant order MEM, MEM, IF, MEM...
//    starve_cnt returns to 0 after the IF grant.
//  4 if_flush pulsed during WAIT of fetch 0x30 -> no if_ready; if_addr changes to 0x80 ->
//    the next fetch issues 0x80 with the normal latency.
//  5 rst=1 for one cycle in WAIT of a load -> next cycle all outputs 0 and state IDLE;
//    mem_ready never pulses for that load; a re-request completes normally.
//  6 Load/store mix, MEM_LATENCY=1 and 4 -> ready exactly MEM_LATENCY+2 cycles after the request;
//    exactly one sram_en per access.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one fixed-latency single-port SRAM between IF and MEM stages
//
// Purpose: sequences each SRAM access as IDLE -> ISSUE -> WAIT -> RESP. MEM has priority
// over IF, and a starvation counter forces an IF grant after STARVE_LIMIT consecutive MEM
// grants with IF waiting. A branch flush discards the response of an in-flight fetch.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr/if_flush   fetch request, PC, branch-taken flush
//   if_rdata/if_ready/if_stall  fetched word, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata  load/store request
//   mem_rdata/mem_ready/mem_stall      load data, completion pulse, stall
//   sram_en/sram_we/sram_addr/sram_wdata  registered SRAM command
//   sram_rdata                SRAM read data, valid MEM_LATENCY cycles after sram_en

module unified_mem_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int ADDR_LEN     = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  input  logic                if_flush,
  output logic [WORD_LEN-1:0] if_rdata,
  output logic                if_ready,
  output logic                if_stall,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_LEN-1:0] mem_addr,
  input  logic [WORD_LEN-1:0] mem_wdata,
  output logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_ready,
  output logic                mem_stall,
  output logic                sram_en,
  output logic                sram_we,
  output logic [ADDR_LEN-1:0] sram_addr,
  output logic [WORD_LEN-1:0] sram_wdata,
  input  logic [WORD_LEN-1:0] sram_rdata
);

  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic GRANT_MEM = 1'b0;
  localparam logic GRANT_IF  = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [LAT_W-1:0]    lat_cnt, lat_cnt_next;
  logic [STV_W-1:0]    starve_cnt, starve_cnt_next;
  logic                grant, grant_next;
  logic                drop_flag, drop_flag_next;
  logic                sram_en_next, sram_we_next;
  logic [ADDR_LEN-1:0] sram_addr_next;
  logic [WORD_LEN-1:0] sram_wdata_next;
  logic [WORD_LEN-1:0] if_rdata_next, mem_rdata_next;
  logic                pick_if;
  logic                any_req;

  // IF wins only when MEM is absent or IF has waited through STARVE_LIMIT MEM grants.
  assign any_req = mem_req | if_req;
  assign pick_if = if_req & (~mem_req | (starve_cnt == STV_W'(STARVE_LIMIT)));

  always_comb begin
    state_next      = state;
    lat_cnt_next    = lat_cnt;
    starve_cnt_next = starve_cnt;
    grant_next      = grant;
    drop_flag_next  = drop_flag;
    sram_en_next    = 1'b0;
    sram_we_next    = sram_we;
    sram_addr_next  = sram_addr;
    sram_wdata_next = sram_wdata;
    if_rdata_next   = if_rdata;
    mem_rdata_next  = mem_rdata;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_next      = pick_if;
          sram_en_next    = 1'b1;
          sram_we_next    = ~pick_if & mem_we;
          sram_addr_next  = pick_if ? if_addr : mem_addr;
          sram_wdata_next = pick_if ? '0 : mem_wdata;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_next = LAT_W'(MEM_LATENCY);
        state_next   = WAIT;
      end
      WAIT: begin
        lat_cnt_next = lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) begin
          // sram_we is held through the access so stores leave mem_rdata untouched.
          if (grant == GRANT_IF) begin
            if_rdata_next = sram_rdata;
          end else if (!sram_we) begin
            mem_rdata_next = sram_rdata;
          end
          state_next = RESP;
        end
      end
      RESP: begin
        drop_flag_next = 1'b0;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A flushed fetch still finishes on the SRAM; only its response is discarded.
    if (if_flush && grant == GRANT_IF && (state == ISSUE || state == WAIT)) begin
      drop_flag_next = 1'b1;
    end

    if (!if_req) begin
      starve_cnt_next = '0;
    end else if (state == IDLE && any_req) begin
      if (pick_if) begin
        starve_cnt_next = '0;
      end else if (starve_cnt < STV_W'(STARVE_LIMIT)) begin
        starve_cnt_next = starve_cnt + STV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      grant      <= GRANT_MEM;
      drop_flag  <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state      <= state_next;
      lat_cnt    <= lat_cnt_next;
      starve_cnt <= starve_cnt_next;
      grant      <= grant_next;
      drop_flag  <= drop_flag_next;
      sram_en    <= sram_en_next;
      sram_we    <= sram_we_next;
      sram_addr  <= sram_addr_next;
      sram_wdata <= sram_wdata_next;
      if_rdata   <= if_rdata_next;
      mem_rdata  <= mem_rdata_next;
    end
  end

  // if_flush during RESP also suppresses the pulse, hence combinational.
  assign if_ready  = (state == RESP) & (grant == GRANT_IF) & ~drop_flag & ~if_flush;
  assign mem_ready = (state == RESP) & (grant == GRANT_MEM);
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - randomized scoreboard bench for unified_mem_arbiter

module tb_unified_mem_arbiter;

  localparam int L   = 2;
  localparam int LIM = 2;
  localparam int TOTAL = 2640;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
  logic        if_ready, if_stall, mem_ready, mem_stall, sram_en, sram_we;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .WORD_LEN(32), .ADDR_LEN(32), .MEM_LATENCY(L), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;

  rsp_t        if_q[$], mem_q[$], rd_q[$];
  acc_t        sram_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] sram_mem[32];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, rst_last = -10;
  bit          started = 1'b0;

  function automatic int idx(input logic [31:0] a);
    return int'(a[6:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against expectations pushed by the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        bit   exp_en, exp_m, exp_i;
        acc_t a;
        rsp_t r;
        if (!rst && cyc == rst_last + 1) begin
          check("rst_sram_en", {31'd0, sram_en}, 32'd0);
          check("rst_sram_we", {31'd0, sram_we}, 32'd0);
          check("rst_sram_addr", sram_addr, 32'd0);
          check("rst_sram_wdata", sram_wdata, 32'd0);
          check("rst_if_rdata", if_rdata, 32'd0);
          check("rst_mem_rdata", mem_rdata, 32'd0);
        end
        exp_en = (sram_q.size() > 0 && sram_q[0].cyc == cyc);
        check("sram_en", {31'd0, sram_en}, {31'd0, exp_en});
        if (exp_en) begin
          a = sram_q.pop_front();
          check("sram_we", {31'd0, sram_we}, {31'd0, a.we});
          check("sram_addr", sram_addr, a.addr);
          if (a.we) check("sram_wdata", sram_wdata, a.wdata);
        end
        exp_m = (mem_q.size() > 0 && mem_q[0].cyc == cyc);
        check("mem_ready", {31'd0, mem_ready}, {31'd0, exp_m});
        check("mem_stall", {31'd0, mem_stall}, {31'd0, mem_req & ~exp_m});
        if (exp_m) begin
          r = mem_q.pop_front();
          check("mem_rdata", mem_rdata, r.data);
        end
        exp_i = (if_q.size() > 0 && if_q[0].cyc == cyc);
        check("if_ready", {31'd0, if_ready}, {31'd0, exp_i});
        check("if_stall", {31'd0, if_stall}, {31'd0, if_req & ~exp_i});
        if (exp_i) begin
          r = if_q.pop_front();
          check("if_rdata", if_rdata, r.data);
        end
      end
    end
  end

  // Driver, SRAM environment and transaction-level reference model.
  initial begin
    int          free_cyc, starve, m_done, i_done, if_g;
    int          pm, pi, pf, pr;
    logic [31:0] last_mem, d, v;
    rsp_t        r;
    acc_t        a;
    bit          pick_if;

    rst = 1'b1; if_req = 0; if_flush = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; sram_rdata = 0;
    free_cyc = 0; starve = 0; m_done = -1; i_done = -1; if_g = -100; last_mem = 0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      sram_mem[i] = v;
    end

    for (int t = 1; t <= TOTAL; t++) begin
      @(posedge clk);
      #1;
      cyc = t;
      started = 1'b1;

      if (t <= 400)       begin pm = 30;  pi = 40;  pf = 0; pr = 0; end
      else if (t <= 900)  begin pm = 100; pi = 100; pf = 0; pr = 0; end
      else if (t <= 1800) begin pm = 40;  pi = 60;  pf = 8; pr = 0; end
      else if (t <= 2600) begin pm = 40;  pi = 60;  pf = 5; pr = 2; end
      else                begin pm = 0;   pi = 0;   pf = 0; pr = 0; end

      // SRAM: data appears exactly L cycles after a read strobe, noise otherwise.
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) void'(rd_q.pop_front());
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        r = rd_q.pop_front();
        sram_rdata = r.data;
      end else begin
        sram_rdata = $urandom;
      end
      if (sram_en === 1'b1) begin
        if (sram_we) sram_mem[idx(sram_addr)] = sram_wdata;
        else begin
          r.cyc = cyc + L;
          r.data = sram_mem[idx(sram_addr)];
          rd_q.push_back(r);
        end
      end

      rst = (t <= 2) || (pr > 0 && $urandom_range(99) < pr);

      // Requesters hold until their predicted completion, then may re-request at once.
      if (mem_req && m_done >= 0 && cyc == m_done + 1) begin mem_req = 0; m_done = -1; end
      if (!mem_req && $urandom_range(99) < pm) begin
        mem_req = 1; mem_we = 1'($urandom_range(1));
        mem_addr = {25'd0, 5'($urandom_range(31)), 2'b00}; mem_wdata = $urandom;
      end
      if (if_req && i_done >= 0 && cyc == i_done + 1) begin if_req = 0; i_done = -1; end
      if (!if_req && $urandom_range(99) < pi) begin
        if_req = 1; if_addr = {25'd0, 5'($urandom_range(31)), 2'b00};
      end
      if_flush = if_req && ($urandom_range(99) < pf);
      if (if_flush) if_addr = {25'd0, 5'($urandom_range(31)), 2'b00};

      // A flush from the cycle after the IF grant through its response cycle drops it.
      if (if_flush && if_g >= 0 && cyc >= if_g + 1 && cyc <= if_g + L + 2) begin
        if (if_q.size() > 0 && if_q[$].cyc >= cyc) void'(if_q.pop_back());
        i_done = -1;
        if_g = -100;
      end

      if (rst) begin
        rst_last = cyc;
        while (if_q.size() > 0 && if_q[$].cyc > cyc) void'(if_q.pop_back());
        while (mem_q.size() > 0 && mem_q[$].cyc > cyc) void'(mem_q.pop_back());
        while (sram_q.size() > 0 && sram_q[$].cyc > cyc) void'(sram_q.pop_back());
        if (m_done > cyc) m_done = -1;
        if (i_done > cyc) i_done = -1;
        if (if_g + L + 2 > cyc) if_g = -100;
        free_cyc = cyc + 1;
        starve = 0;
        last_mem = 0;
      end else begin
        if (cyc >= free_cyc && (mem_req || if_req)) begin
          pick_if = if_req && (!mem_req || starve == LIM);
          a.cyc = cyc + 1;
          r.cyc = cyc + L + 2;
          if (pick_if) begin
            a.we = 0; a.addr = if_addr; a.wdata = 0;
            r.data = ref_mem[idx(if_addr)];
            if_q.push_back(r);
            i_done = cyc + L + 2;
            if_g = cyc;
            starve = 0;
          end else begin
            a.we = mem_we; a.addr = mem_addr; a.wdata = mem_wdata;
            if (mem_we) begin
              ref_mem[idx(mem_addr)] = mem_wdata;
              d = last_mem;
            end else begin
              d = ref_mem[idx(mem_addr)];
              last_mem = d;
            end
            r.data = d;
            mem_q.push_back(r);
            m_done = cyc + L + 2;
            if (if_req && starve < LIM) starve++;
          end
          sram_q.push_back(a);
          free_cyc = cyc + L + 3;
        end
        if (!if_req) starve = 0;
      end
    end

    @(negedge clk);
    #1;
    check("if_q_drained", if_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("sram_q_drained", sram_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
